e_muldiv: RTL and testbench

- Parametrised multi-cycle integer multiply/divide unit. Sits in the execute stage beside the single-cycle ALU.
- Takes one operation at a time over a valid/ready request handshake and returns the result over a valid/ready response handshake.
- Multiply uses a configurable-depth pipeline. Divide uses an iterative radix-2 restoring divider with signed fix-up.
- Supports a flush that abandons the in-flight operation.

---
 rtl/e_muldiv.sv | 192 +++++++++++++++++++
 tb/tb_e_muldiv.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_muldiv.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : e_muldiv                                                 |
// | Description : Multi-cycle integer multiply/divide unit. Multiply has a |
// |               fixed configurable latency; divide is radix-2 restoring  |
// |               on magnitudes with a final sign fix-up cycle.            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module e_muldiv #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] r0_i,
  input  logic [WIDTH-1:0] r1_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] resp_tag_o
);

  // Counter is shared by the multiply wait and the divide iterations.
  localparam int              CNT_W    = $clog2(WIDTH + MUL_STAGES) + 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULH  = 3'd1;
  localparam logic [2:0] OP_MULHU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MOD   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;
  localparam logic [2:0] OP_MODU  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             want_rem_q, want_rem_d;

  logic               is_mul, is_div, mul_signed, div_signed, accept;
  logic [2*WIDTH-1:0] mul_a, mul_b, mul_p;
  logic [WIDTH-1:0]   mul_res, abs_r0, abs_r1;
  logic [WIDTH:0]     shifted, trial;

  // Operand decode, full-width product and one restoring-divide step.
  always_comb begin
    is_mul     = (op_i == OP_MUL) | (op_i == OP_MULH) | (op_i == OP_MULHU);
    is_div     = (op_i >= OP_DIV) && (op_i <= OP_MODU);
    mul_signed = (op_i == OP_MULH);
    div_signed = (op_i == OP_DIV) | (op_i == OP_MOD);
    // Extending to 2*WIDTH makes the low 2*WIDTH product bits exact for
    // both signed and unsigned interpretations.
    mul_a   = {{WIDTH{mul_signed & r0_i[WIDTH-1]}}, r0_i};
    mul_b   = {{WIDTH{mul_signed & r1_i[WIDTH-1]}}, r1_i};
    mul_p   = mul_a * mul_b;
    mul_res = (op_i == OP_MUL) ? mul_p[WIDTH-1:0] : mul_p[2*WIDTH-1:WIDTH];
    // Most-negative magnitude is representable as an unsigned value.
    abs_r0  = (div_signed & r0_i[WIDTH-1]) ? -r0_i : r0_i;
    abs_r1  = (div_signed & r1_i[WIDTH-1]) ? -r1_i : r1_i;
    // Partial remainder stays below the divisor, so a negative trial is
    // flagged by its top bit.
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dsr_q};
  end

  // Next-state, handshake and datapath register updates.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    tag_d      = tag_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dsr_d      = dsr_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    want_rem_d = want_rem_q;
    req_ready_o = (state_q == S_IDLE) & ~flush_i;
    accept      = req_valid_i & req_ready_o;

    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            tag_d = tag_i;
            cnt_d = '0;
            if (is_mul) begin
              // Product is captured at accept and held for the remaining
              // stages, leaving room for retiming across the wait cycles.
              result_d = mul_res;
              state_d  = (MUL_STAGES > 1) ? S_MUL : S_DONE;
            end else if (is_div && (r1_i != '0)) begin
              rem_d      = '0;
              quo_d      = abs_r0;
              dsr_d      = abs_r1;
              neg_quo_d  = div_signed & (r0_i[WIDTH-1] ^ r1_i[WIDTH-1]);
              neg_rem_d  = div_signed & r0_i[WIDTH-1];
              want_rem_d = (op_i == OP_MOD) | (op_i == OP_MODU);
              state_d    = S_DIV;
            end else if (is_div) begin
              result_d = ((op_i == OP_DIV) | (op_i == OP_DIVU)) ? '1 : r0_i;
              state_d  = S_DONE;
            end else begin
              result_d = '0;
              state_d  = S_DONE;
            end
          end
        end
        S_MUL: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == MUL_LAST) state_d = S_DONE;
        end
        S_DIV: begin
          cnt_d = cnt_q + 1'b1;
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == DIV_LAST) state_d = S_FIX;
        end
        S_FIX: begin
          result_d = want_rem_q ? (neg_rem_q ? -rem_q : rem_q)
                                : (neg_quo_q ? -quo_q : quo_q);
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (resp_ready_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      result_q   <= '0;
      tag_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dsr_q      <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      want_rem_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      tag_q      <= tag_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dsr_q      <= dsr_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      want_rem_q <= want_rem_d;
    end
  end

  assign resp_valid_o = (state_q == S_DONE);
  assign result_o     = result_q;
  assign resp_tag_o   = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_e_muldiv.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_e_muldiv                                              |
// | Description : Self-checking bench for e_muldiv with an arithmetic      |
// |               reference model, directed cases and random traffic.      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_e_muldiv;
  localparam int WIDTH      = 32;
  localparam int MUL_STAGES = 2;
  localparam int TAG_W      = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush_i = 1'b0;
  logic              req_valid_i = 1'b0;
  logic              resp_ready_i = 1'b1;
  logic [2:0]        op_i = '0;
  logic [WIDTH-1:0]  r0_i = '0;
  logic [WIDTH-1:0]  r1_i = '0;
  logic [TAG_W-1:0]  tag_i = '0;
  logic              req_ready_o, resp_valid_o;
  logic [WIDTH-1:0]  result_o;
  logic [TAG_W-1:0]  resp_tag_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: one outstanding operation with its due cycle.
  bit               pending = 1'b0;
  int               due = 0;
  int               cyc = 0;
  logic [WIDTH-1:0] exp_res = '0;
  logic [TAG_W-1:0] exp_tag = '0;

  e_muldiv #(.WIDTH(WIDTH), .MUL_STAGES(MUL_STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .r0_i(r0_i), .r1_i(r1_i), .tag_i(tag_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .result_o(result_o), .resp_tag_o(resp_tag_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected result straight from the arithmetic definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] p;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd4: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b);
    if (op <= 3'd2) return MUL_STAGES;
    if (op <= 3'd6 && b != 0) return WIDTH + 2;
    return 1;
  endfunction

  // Per-cycle comparison against the model, then advance the model.
  always @(negedge clk) begin
    bit exp_valid;
    cyc++;
    if (!rst_n) begin
      pending = 1'b0;
      check("rst_resp_valid", resp_valid_o, 0);
      check("rst_result", result_o, 0);
      check("rst_tag", resp_tag_o, 0);
      check("rst_req_ready", req_ready_o, !flush_i);
    end else begin
      exp_valid = pending && (cyc >= due);
      check("req_ready", req_ready_o, !pending && !flush_i);
      check("resp_valid", resp_valid_o, exp_valid);
      if (exp_valid && resp_valid_o) begin
        check("result", result_o, exp_res);
        check("resp_tag", resp_tag_o, exp_tag);
      end
      if (flush_i) begin
        pending = 1'b0;
      end else if (pending) begin
        if (exp_valid && resp_ready_i) pending = 1'b0;
      end else if (req_valid_i) begin
        pending = 1'b1;
        exp_res = ref_result(op_i, r0_i, r1_i);
        exp_tag = tag_i;
        due     = cyc + ref_latency(op_i, r1_i);
      end
    end
  end

  // Full request/response with literal expectations; resp_ready_i stays 1.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] tag,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    bit got;
    @(posedge clk); #1;
    req_valid_i = 1'b1; op_i = op; r0_i = a; r1_i = b; tag_i = tag;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready_o) got = 1'b1;
    end
    check({name, "_accept"}, got, 1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (resp_valid_o) got = 1'b1;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_value"}, result_o, exp);
    check({name, "_tag"}, resp_tag_o, tag);
  endtask

  // One-cycle request; caller guarantees the unit is idle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
    @(posedge clk); #1;
    req_valid_i = 1'b1; op_i = op; r0_i = a; r1_i = b; tag_i = tag;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (resp_valid_o) got = 1'b1;
    end
    check({name, "_wait_valid"}, got, 1);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    #23 rst_n = 1'b1;

    // Pin the model against hand-computed values.
    check("model_mulh", ref_result(3'd1, 32'hFFFF_FFFF, 32'h2), 64'hFFFF_FFFF);
    check("model_mod", ref_result(3'd4, 32'hFFFF_FFF9, 32'h2), 64'hFFFF_FFFF);

    // Multiply family.
    run_op("mul",   3'd0, 32'hFFFF_FFFF, 32'h2, 6'h01, 32'hFFFF_FFFE, 2);
    run_op("mulh",  3'd1, 32'hFFFF_FFFF, 32'h2, 6'h02, 32'hFFFF_FFFF, 2);
    run_op("mulhu", 3'd2, 32'hFFFF_FFFF, 32'h2, 6'h03, 32'h0000_0001, 2);
    // Divide family.
    run_op("div",   3'd3, 32'hFFFF_FFF9, 32'h2, 6'h04, 32'hFFFF_FFFD, 34);
    run_op("mod",   3'd4, 32'hFFFF_FFF9, 32'h2, 6'h05, 32'hFFFF_FFFF, 34);
    run_op("divu",  3'd5, 32'hFFFF_FFF9, 32'h2, 6'h06, 32'h7FFF_FFFC, 34);
    run_op("modu",  3'd6, 32'hFFFF_FFF9, 32'h2, 6'h07, 32'h0000_0001, 34);
    // Boundaries.
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 6'h08, 32'h8000_0000, 34);
    run_op("mod_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 6'h09, 32'h0, 34);
    run_op("divu_z",  3'd5, 32'h5, 32'h0, 6'h0A, 32'hFFFF_FFFF, 1);
    run_op("modu_z",  3'd6, 32'h5, 32'h0, 6'h0B, 32'h5, 1);
    run_op("rsvd",    3'd7, 32'h1234, 32'h5678, 6'h0C, 32'h0, 1);

    // Backpressure: response held for 5 cycles.
    @(posedge clk); #1 resp_ready_i = 1'b0;
    issue(3'd0, 32'd7, 32'd9, 6'h15);
    wait_valid("bp");
    held = result_o;
    check("bp_first", held, 32'd63);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", resp_valid_o, 1);
      check("bp_result", result_o, 32'd63);
      check("bp_tag", resp_tag_o, 6'h15);
      check("bp_req_ready", req_ready_o, 0);
    end
    @(posedge clk); #1 resp_ready_i = 1'b1;
    @(negedge clk);
    check("bp_release_same", req_ready_o, 0);
    @(negedge clk);
    check("bp_release_next", req_ready_o, 1);

    // Flush during divide iteration 10: no response ever appears.
    issue(3'd3, 32'd1000, 32'd7, 6'h16);
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;
    @(negedge clk);
    check("flush_div_idle", req_ready_o, 1);
    check("flush_div_valid", resp_valid_o, 0);
    repeat (40) @(posedge clk);

    // Request during flush is refused.
    @(posedge clk); #1;
    flush_i = 1'b1; req_valid_i = 1'b1; op_i = 3'd0; r0_i = 32'd2; r1_i = 32'd3; tag_i = 6'h17;
    @(negedge clk);
    check("flush_req_ready", req_ready_o, 0);
    @(posedge clk); #1 flush_i = 1'b0; req_valid_i = 1'b0;
    @(negedge clk);
    check("flush_req_not_taken", req_ready_o, 1);

    // Flush while a response is presented.
    resp_ready_i = 1'b0;
    issue(3'd5, 32'd5, 32'd0, 6'h18);
    wait_valid("flush_done");
    @(posedge clk); #1 flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0; resp_ready_i = 1'b1;
    @(negedge clk);
    check("flush_done_drop", resp_valid_o, 0);

    // Asynchronous reset mid-multiply.
    issue(3'd0, 32'h1234, 32'h10, 6'h2A);
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid", resp_valid_o, 0);
    check("areset_result", result_o, 0);
    check("areset_tag", resp_tag_o, 0);
    check("areset_ready", req_ready_o, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_op("post_reset_mul", 3'd0, 32'd3, 32'd4, 6'h05, 32'd12, 2);

    // Random traffic with flush and backpressure, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      req_valid_i  = 1'($urandom_range(0, 1));
      op_i         = 3'($urandom_range(0, 7));
      r0_i         = rand_operand();
      r1_i         = rand_operand();
      tag_i        = 6'($urandom);
      resp_ready_i = ($urandom_range(0, 3) != 0);
      flush_i      = ($urandom_range(0, 49) == 0);
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0; flush_i = 1'b0; resp_ready_i = 1'b1;
    repeat (60) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
